wb_issue: RTL and testbench

WB_ISSUE -- requirements
Module: wb_issue

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 84 ++++++++
 rtl/wb_issue.sv | 143 ++++++++++++++
 tb/tb_wb_issue.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback issue block.
package wb_pkg;

  localparam int XCNT_DEF  = 32;
  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 4;
  localparam int SEL_W_DEF = $clog2(XCNT_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [SEL_W_DEF-1:0] sel;
    logic [XLEN_DEF-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Result queue feeding the writeback issuer. Besides push/pop it can
// discard everything behind the head (the head may be mid-write) and
// exposes per-entry valid/sel so the issuer can answer hazard queries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DATA_W = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push,
  input  logic [SEL_W-1:0]            push_sel,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  input  logic                        flush,
  input  logic                        keep_head,
  output logic                        full,
  output logic                        empty,
  output logic [CNT_W-1:0]            count,
  output logic [SEL_W-1:0]            head_sel,
  output logic [DATA_W-1:0]           head_data,
  output logic [SEL_W-1:0]            next_sel,
  output logic [DATA_W-1:0]           next_data,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH-1:0][SEL_W-1:0] entry_sel
);

  logic [SEL_W-1:0]  sel_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Storage needs no reset; only entries inside [rd_ptr, rd_ptr+count) are ever used.
  always_ff @(posedge CLK) begin
    if (push) begin
      sel_mem[wr_ptr]  <= push_sel;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping, including the keep-head discard.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      if (keep_head && !pop && (count != '0)) begin
        wr_ptr <= rd_ptr + PTR_W'(1);
        count  <= CNT_W'(1);
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= rd_ptr + PTR_W'(pop);
        count  <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_sel  = sel_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign next_sel  = sel_mem[rd_ptr + PTR_W'(1)];
  assign next_data = data_mem[rd_ptr + PTR_W'(1)];

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign entry_valid[g] = ({1'b0, PTR_W'(g) - rd_ptr} < count);
    assign entry_sel[g]   = sel_mem[g];
  end

endmodule

// File: rtl/wb_issue.sv
// Writeback issuer: queues register-writing results, presents them one at a
// time to the writeback stage, reports pending-write hazards to decode and
// pulses a release when each write commits.
//
// state | meaning
// IDLE  | nothing presented; waits for a queued result
// ISSUE | queue head presented on WB_*, waiting for WB_VALID
module wb_issue
  import wb_pkg::*;
#(
  parameter int XCNT  = XCNT_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int SEL_W = $clog2(XCNT),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RES_VALID,
  output logic             RES_READY,
  input  logic             RES_WE,
  input  logic [SEL_W-1:0] RES_SEL,
  input  logic [XLEN-1:0]  RES_DATA,
  input  logic             FLUSH,
  output logic             WB_ENABLED,
  output logic [SEL_W-1:0] WB_WRITE_SEL,
  output logic [XLEN-1:0]  WB_WRITE_DATA,
  input  logic             WB_VALID,
  input  logic [SEL_W-1:0] CHK_SEL1,
  input  logic [SEL_W-1:0] CHK_SEL2,
  output logic             CHK_BUSY1,
  output logic             CHK_BUSY2,
  output logic             RELEASE_HAZARD,
  output logic [SEL_W-1:0] RELEASE_SEL
);

  wb_state_t                  state;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CNT_W-1:0]           fifo_count;
  logic [SEL_W-1:0]           head_sel;
  logic [XLEN-1:0]            head_data;
  logic [SEL_W-1:0]           next_sel;
  logic [XLEN-1:0]            next_data;
  logic [DEPTH-1:0]           entry_valid;
  logic [DEPTH-1:0][SEL_W-1:0] entry_sel;
  logic                       push_eff;
  logic                       pop;
  logic                       stay_issue;
  logic [SEL_W-1:0]           follow_sel;
  logic [XLEN-1:0]            follow_data;

  assign RES_READY = !fifo_full;

  // Results that write nothing (no WE or x0) are consumed but never queued.
  assign push_eff = RES_VALID && !fifo_full && RES_WE && (RES_SEL != '0) && !FLUSH;
  assign pop      = (state == ISSUE) && WB_VALID;

  // After a pop the next head is either the second entry or, if the queue
  // held only the head, the result arriving this very cycle.
  assign stay_issue  = !FLUSH && ((fifo_count > CNT_W'(1)) || push_eff);
  assign follow_sel  = (fifo_count > CNT_W'(1)) ? next_sel  : RES_SEL;
  assign follow_data = (fifo_count > CNT_W'(1)) ? next_data : RES_DATA;

  wb_fifo #(
    .SEL_W  (SEL_W),
    .DATA_W (XLEN),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push        (push_eff),
    .push_sel    (RES_SEL),
    .push_data   (RES_DATA),
    .pop         (pop),
    .flush       (FLUSH),
    .keep_head   (state == ISSUE),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .head_sel    (head_sel),
    .head_data   (head_data),
    .next_sel    (next_sel),
    .next_data   (next_data),
    .entry_valid (entry_valid),
    .entry_sel   (entry_sel)
  );

  // Issue FSM with registered writeback and release outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      WB_ENABLED     <= 1'b0;
      WB_WRITE_SEL   <= '0;
      WB_WRITE_DATA  <= '0;
      RELEASE_HAZARD <= 1'b0;
      RELEASE_SEL    <= '0;
    end else begin
      RELEASE_HAZARD <= 1'b0;
      case (state)
        IDLE: begin
          // A flush in this cycle empties the queue, so there is nothing to issue.
          if (!fifo_empty && !FLUSH) begin
            state         <= ISSUE;
            WB_ENABLED    <= 1'b1;
            WB_WRITE_SEL  <= head_sel;
            WB_WRITE_DATA <= head_data;
          end
        end
        ISSUE: begin
          if (WB_VALID) begin
            RELEASE_HAZARD <= 1'b1;
            RELEASE_SEL    <= WB_WRITE_SEL;
            if (stay_issue) begin
              WB_WRITE_SEL  <= follow_sel;
              WB_WRITE_DATA <= follow_data;
            end else begin
              state      <= IDLE;
              WB_ENABLED <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          WB_ENABLED <= 1'b0;
        end
      endcase
    end
  end

  // Hazard query: any live entry, including the one being written, blocks its register.
  always_comb begin
    CHK_BUSY1 = 1'b0;
    CHK_BUSY2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_sel[i] == CHK_SEL1)) CHK_BUSY1 = 1'b1;
      if (entry_valid[i] && (entry_sel[i] == CHK_SEL2)) CHK_BUSY2 = 1'b1;
    end
    if (CHK_SEL1 == '0) CHK_BUSY1 = 1'b0;
    if (CHK_SEL2 == '0) CHK_BUSY2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_issue.sv
// Scenario bench for wb_issue: results expected to be written are queued as
// they are offered and retired against what appears on the WB_* port.
module tb_wb_issue;
  import wb_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RES_VALID;
  logic        RES_READY;
  logic        RES_WE;
  logic [4:0]  RES_SEL;
  logic [31:0] RES_DATA;
  logic        FLUSH;
  logic        WB_ENABLED;
  logic [4:0]  WB_WRITE_SEL;
  logic [31:0] WB_WRITE_DATA;
  logic        WB_VALID;
  logic [4:0]  CHK_SEL1;
  logic [4:0]  CHK_SEL2;
  logic        CHK_BUSY1;
  logic        CHK_BUSY2;
  logic        RELEASE_HAZARD;
  logic [4:0]  RELEASE_SEL;

  wb_entry_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  wb_issue #(.XCNT(32), .XLEN(32), .DEPTH(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .RES_VALID      (RES_VALID),
    .RES_READY      (RES_READY),
    .RES_WE         (RES_WE),
    .RES_SEL        (RES_SEL),
    .RES_DATA       (RES_DATA),
    .FLUSH          (FLUSH),
    .WB_ENABLED     (WB_ENABLED),
    .WB_WRITE_SEL   (WB_WRITE_SEL),
    .WB_WRITE_DATA  (WB_WRITE_DATA),
    .WB_VALID       (WB_VALID),
    .CHK_SEL1       (CHK_SEL1),
    .CHK_SEL2       (CHK_SEL2),
    .CHK_BUSY1      (CHK_BUSY1),
    .CHK_BUSY2      (CHK_BUSY2),
    .RELEASE_HAZARD (RELEASE_HAZARD),
    .RELEASE_SEL    (RELEASE_SEL)
  );

  task automatic idle_inputs();
    RES_VALID = 1'b0; RES_WE = 1'b0; RES_SEL = '0; RES_DATA = '0;
    FLUSH = 1'b0; WB_VALID = 1'b0; CHK_SEL1 = '0; CHK_SEL2 = '0;
  endtask

  task automatic offer(input logic we, input logic [4:0] sel, input logic [31:0] data);
    RES_VALID = 1'b1; RES_WE = we; RES_SEL = sel; RES_DATA = data;
  endtask

  // Update the expected-write queue from the inputs about to be clocked, then
  // advance one cycle and settle just after the edge.
  task automatic clk_step();
    wb_entry_t e;
    if (RST) begin
      exp_q.delete();
    end else if (FLUSH) begin
      if (WB_ENABLED && !WB_VALID && exp_q.size() > 0) begin
        e = exp_q[0];
        exp_q.delete();
        exp_q.push_back(e);
      end else begin
        exp_q.delete();
      end
    end else if (RES_VALID && RES_READY && RES_WE && RES_SEL != 5'd0) begin
      e.sel = RES_SEL; e.data = RES_DATA;
      exp_q.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    CHK_SEL1 = 5'd5;
    clk_step(); clk_step();
    RST = 1'b0;
    n_checks++; if (WB_ENABLED !== 1'b0) $display("FAIL reset_wb_en: got %0b want 0", WB_ENABLED); else n_pass++;
    n_checks++; if (RELEASE_HAZARD !== 1'b0) $display("FAIL reset_release: got %0b want 0", RELEASE_HAZARD); else n_pass++;
    n_checks++; if (RELEASE_SEL !== 5'd0) $display("FAIL reset_release_sel: got %0d want 0", RELEASE_SEL); else n_pass++;
    n_checks++; if (WB_WRITE_SEL !== 5'd0) $display("FAIL reset_wb_sel: got %0d want 0", WB_WRITE_SEL); else n_pass++;
    n_checks++; if (WB_WRITE_DATA !== 32'd0) $display("FAIL reset_wb_data: got %h want 0", WB_WRITE_DATA); else n_pass++;
    n_checks++; if (RES_READY !== 1'b1) $display("FAIL reset_ready: got %0b want 1", RES_READY); else n_pass++;
    n_checks++; if (CHK_BUSY1 !== 1'b0) $display("FAIL reset_busy1: got %0b want 0", CHK_BUSY1); else n_pass++;
  endtask

  task automatic test_single();
    wb_entry_t e;
    idle_inputs();
    CHK_SEL1 = 5'd5;
    offer(1'b1, 5'd5, 32'hDEADBEEF);
    clk_step();
    RES_VALID = 1'b0;
    n_checks++; if (CHK_BUSY1 !== 1'b1) $display("FAIL single_busy_after_push: got %0b want 1", CHK_BUSY1); else n_pass++;
    n_checks++; if (WB_ENABLED !== 1'b0) $display("FAIL single_latency_early: got %0b want 0", WB_ENABLED); else n_pass++;
    clk_step();
    n_checks++; if (WB_ENABLED !== 1'b1) $display("FAIL single_latency: got %0b want 1", WB_ENABLED); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      clk_step();
      n_checks++;
      if (WB_ENABLED !== 1'b1 || WB_WRITE_SEL !== 5'd5 || WB_WRITE_DATA !== 32'hDEADBEEF)
        $display("FAIL single_hold_%0d: got en=%0b sel=%0d data=%h want en=1 sel=5 data=deadbeef", c, WB_ENABLED, WB_WRITE_SEL, WB_WRITE_DATA);
      else n_pass++;
      n_checks++; if (CHK_BUSY1 !== 1'b1) $display("FAIL single_busy_hold_%0d: got %0b want 1", c, CHK_BUSY1); else n_pass++;
    end
    WB_VALID = 1'b1;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL single_sb_empty: got empty queue want one entry");
    else begin
      e = exp_q.pop_front();
      if (WB_WRITE_SEL !== e.sel || WB_WRITE_DATA !== e.data)
        $display("FAIL single_write: got sel=%0d data=%h want sel=%0d data=%h", WB_WRITE_SEL, WB_WRITE_DATA, e.sel, e.data);
      else n_pass++;
    end
    clk_step();
    WB_VALID = 1'b0;
    n_checks++; if (RELEASE_HAZARD !== 1'b1 || RELEASE_SEL !== 5'd5) $display("FAIL single_release: got rel=%0b sel=%0d want rel=1 sel=5", RELEASE_HAZARD, RELEASE_SEL); else n_pass++;
    n_checks++; if (WB_ENABLED !== 1'b0) $display("FAIL single_idle_after: got %0b want 0", WB_ENABLED); else n_pass++;
    n_checks++; if (CHK_BUSY1 !== 1'b0) $display("FAIL single_busy_cleared: got %0b want 0", CHK_BUSY1); else n_pass++;
    clk_step();
    n_checks++; if (RELEASE_HAZARD !== 1'b0) $display("FAIL single_release_pulse: got %0b want 0", RELEASE_HAZARD); else n_pass++;
  endtask

  task automatic test_full();
    wb_entry_t e;
    int n_wr;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i));
      clk_step();
    end
    offer(1'b1, 5'd6, 32'hA000_0006);
    n_checks++; if (RES_READY !== 1'b0) $display("FAIL full_ready: got %0b want 0", RES_READY); else n_pass++;
    clk_step();
    n_checks++; if (RES_READY !== 1'b0) $display("FAIL full_stall: got %0b want 0", RES_READY); else n_pass++;
    n_checks++; if (WB_WRITE_SEL !== 5'd1) $display("FAIL full_head: got %0d want 1", WB_WRITE_SEL); else n_pass++;
    WB_VALID = 1'b1;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL full_sb_empty: got empty queue want entries");
    else begin
      e = exp_q.pop_front();
      if (WB_WRITE_SEL !== e.sel || WB_WRITE_DATA !== e.data)
        $display("FAIL full_first_write: got sel=%0d data=%h want sel=%0d data=%h", WB_WRITE_SEL, WB_WRITE_DATA, e.sel, e.data);
      else n_pass++;
    end
    clk_step();
    WB_VALID = 1'b0;
    n_checks++; if (RES_READY !== 1'b1) $display("FAIL full_ready_after_ack: got %0b want 1", RES_READY); else n_pass++;
    n_checks++; if (RELEASE_HAZARD !== 1'b1 || RELEASE_SEL !== 5'd1) $display("FAIL full_release: got rel=%0b sel=%0d want rel=1 sel=1", RELEASE_HAZARD, RELEASE_SEL); else n_pass++;
    clk_step();
    RES_VALID = 1'b0;
    WB_VALID = 1'b1;
    n_wr = 0;
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) begin
      if (WB_ENABLED) begin
        e = exp_q.pop_front();
        n_wr++;
        n_checks++;
        if (WB_WRITE_SEL !== e.sel || WB_WRITE_DATA !== e.data)
          $display("FAIL full_order_%0d: got sel=%0d data=%h want sel=%0d data=%h", n_wr, WB_WRITE_SEL, WB_WRITE_DATA, e.sel, e.data);
        else n_pass++;
      end
      clk_step();
    end
    WB_VALID = 1'b0;
    n_checks++; if (n_wr != 4) $display("FAIL full_drain_count: got %0d writes want 4", n_wr); else n_pass++;
    n_checks++; if (WB_ENABLED !== 1'b0) $display("FAIL full_drained_idle: got %0b want 0", WB_ENABLED); else n_pass++;
    clk_step();
  endtask

  task automatic test_back_to_back();
    wb_entry_t e;
    logic popped;
    logic [4:0] psel;
    int n_wr, first_k, last_k;
    idle_inputs();
    WB_VALID = 1'b1;
    n_wr = 0; first_k = -1; last_k = -1; psel = '0;
    for (int k = 0; k < 7; k++) begin
      popped = 1'b0;
      if (k < 3) offer(1'b1, 5'(k + 1), 32'h0000_00B0 + 32'(k));
      else RES_VALID = 1'b0;
      if (WB_ENABLED) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_unexpected_write: got sel=%0d want none", WB_WRITE_SEL);
        else begin
          e = exp_q.pop_front();
          if (WB_WRITE_SEL !== e.sel || WB_WRITE_DATA !== e.data)
            $display("FAIL b2b_write_%0d: got sel=%0d data=%h want sel=%0d data=%h", k, WB_WRITE_SEL, WB_WRITE_DATA, e.sel, e.data);
          else n_pass++;
          popped = 1'b1; psel = e.sel; n_wr++;
          if (first_k < 0) first_k = k;
          last_k = k;
        end
      end
      clk_step();
      n_checks++; if (RELEASE_HAZARD !== popped) $display("FAIL b2b_release_%0d: got %0b want %0b", k, RELEASE_HAZARD, popped); else n_pass++;
      if (popped) begin
        n_checks++; if (RELEASE_SEL !== psel) $display("FAIL b2b_release_sel_%0d: got %0d want %0d", k, RELEASE_SEL, psel); else n_pass++;
      end
    end
    WB_VALID = 1'b0;
    n_checks++; if (n_wr != 3 || (last_k - first_k) != 2) $display("FAIL b2b_consecutive: got %0d writes span %0d want 3 span 2", n_wr, last_k - first_k); else n_pass++;
  endtask

  task automatic test_drops();
    idle_inputs();
    CHK_SEL1 = 5'd7;
    CHK_SEL2 = 5'd0;
    offer(1'b0, 5'd7, 32'h7777_7777);
    n_checks++; if (RES_READY !== 1'b1) $display("FAIL drop_ready: got %0b want 1", RES_READY); else n_pass++;
    clk_step();
    n_checks++; if (CHK_BUSY1 !== 1'b0) $display("FAIL drop_we0_busy: got %0b want 0", CHK_BUSY1); else n_pass++;
    offer(1'b1, 5'd0, 32'h0000_1234);
    clk_step();
    RES_VALID = 1'b0;
    n_checks++; if (CHK_BUSY2 !== 1'b0) $display("FAIL drop_sel0_busy: got %0b want 0", CHK_BUSY2); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (WB_ENABLED !== 1'b0 || CHK_BUSY1 !== 1'b0 || RELEASE_HAZARD !== 1'b0)
        $display("FAIL drop_quiet_%0d: got en=%0b busy=%0b rel=%0b want all 0", c, WB_ENABLED, CHK_BUSY1, RELEASE_HAZARD);
      else n_pass++;
      clk_step();
    end
  endtask

  task automatic test_flush();
    wb_entry_t e;
    idle_inputs();
    offer(1'b1, 5'd4, 32'h0000_00C4); clk_step();
    offer(1'b1, 5'd9, 32'h0000_00C9); clk_step();
    offer(1'b1, 5'd10, 32'h0000_00CA); clk_step();
    RES_VALID = 1'b0;
    CHK_SEL1 = 5'd9; #1;
    n_checks++; if (CHK_BUSY1 !== 1'b1) $display("FAIL flush_busy_before: got %0b want 1", CHK_BUSY1); else n_pass++;
    n_checks++; if (WB_ENABLED !== 1'b1 || WB_WRITE_SEL !== 5'd4) $display("FAIL flush_head_issuing: got en=%0b sel=%0d want en=1 sel=4", WB_ENABLED, WB_WRITE_SEL); else n_pass++;
    FLUSH = 1'b1;
    offer(1'b1, 5'd11, 32'h0000_00CB);
    clk_step();
    FLUSH = 1'b0;
    RES_VALID = 1'b0;
    CHK_SEL2 = 5'd4; #1;
    n_checks++; if (CHK_BUSY1 !== 1'b0) $display("FAIL flush_discarded_busy: got %0b want 0", CHK_BUSY1); else n_pass++;
    n_checks++; if (CHK_BUSY2 !== 1'b1) $display("FAIL flush_head_busy: got %0b want 1", CHK_BUSY2); else n_pass++;
    CHK_SEL1 = 5'd11; #1;
    n_checks++; if (CHK_BUSY1 !== 1'b0) $display("FAIL flush_push_dropped: got %0b want 0", CHK_BUSY1); else n_pass++;
    WB_VALID = 1'b1;
    n_checks++;
    if (exp_q.size() != 1) $display("FAIL flush_sb_size: got %0d entries want 1", exp_q.size());
    else begin
      e = exp_q.pop_front();
      if (WB_ENABLED !== 1'b1 || WB_WRITE_SEL !== e.sel || WB_WRITE_DATA !== e.data)
        $display("FAIL flush_head_write: got en=%0b sel=%0d data=%h want en=1 sel=%0d data=%h", WB_ENABLED, WB_WRITE_SEL, WB_WRITE_DATA, e.sel, e.data);
      else n_pass++;
    end
    clk_step();
    n_checks++; if (RELEASE_HAZARD !== 1'b1 || RELEASE_SEL !== 5'd4) $display("FAIL flush_release: got rel=%0b sel=%0d want rel=1 sel=4", RELEASE_HAZARD, RELEASE_SEL); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      clk_step();
      n_checks++;
      if (WB_ENABLED !== 1'b0 || RELEASE_HAZARD !== 1'b0)
        $display("FAIL flush_empty_after_%0d: got en=%0b rel=%0b want 0 0", c, WB_ENABLED, RELEASE_HAZARD);
      else n_pass++;
    end
    n_checks++; if (CHK_BUSY2 !== 1'b0) $display("FAIL flush_head_busy_cleared: got %0b want 0", CHK_BUSY2); else n_pass++;
    WB_VALID = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    idle_inputs();
    CHK_SEL1 = 5'd12;
    offer(1'b1, 5'd12, 32'h1234_5678);
    clk_step();
    RES_VALID = 1'b0;
    clk_step();
    n_checks++; if (WB_ENABLED !== 1'b1) $display("FAIL rstmid_issuing: got %0b want 1", WB_ENABLED); else n_pass++;
    RST = 1'b1;
    clk_step();
    RST = 1'b0;
    n_checks++; if (WB_ENABLED !== 1'b0 || RELEASE_HAZARD !== 1'b0) $display("FAIL rstmid_abandon: got en=%0b rel=%0b want 0 0", WB_ENABLED, RELEASE_HAZARD); else n_pass++;
    n_checks++; if (CHK_BUSY1 !== 1'b0) $display("FAIL rstmid_busy: got %0b want 0", CHK_BUSY1); else n_pass++;
    WB_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clk_step();
      n_checks++;
      if (WB_ENABLED !== 1'b0 || RELEASE_HAZARD !== 1'b0)
        $display("FAIL rstmid_late_ack_%0d: got en=%0b rel=%0b want 0 0", c, WB_ENABLED, RELEASE_HAZARD);
      else n_pass++;
    end
    WB_VALID = 1'b0;
    n_checks++; if (RES_READY !== 1'b1) $display("FAIL rstmid_ready: got %0b want 1", RES_READY); else n_pass++;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_drops();
    test_flush();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
